operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have ports: clock  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high.
REQ-003 SHALL have: in_valid in 1, in_ready out 1, in_rs1 in 5, in_rs2 in 5, in_rd in 5, in_rd_wen in 1, in_pc in 64  decoded-instruction handshake.
REQ-004 SHALL have: rf_rs1 out 5, rf_rs2 out 5  register-file read addresses; rf_src1 in 64, rf_src2 in 64  read data, combinational.
REQ-005 SHALL have: wb_waddr in 5, wb_wen in 1, wb_wdata in 64  writeback port snooped, same signals that write the register file.
REQ-006 SHALL have: out_valid out 1, out_ready in 1, out_src1 out 64, out_src2 out 64, out_rd out 5, out_rd_wen out 1, out_pc out 64  execute-stage handshake.

Function
REQ-007 SHALL implement FSM states EMPTY, RESOLVE, FULL; in_ready = (state==EMPTY) or (state==FULL and out_ready).
REQ-008 SHALL capture in_rs1/rs2/rd/rd_wen/pc into a hold register on in_valid&&in_ready; next state RESOLVE.
REQ-009 SHALL drive rf_rs1/rf_rs2 combinationally from the hold register.
REQ-010 SHALL keep a 32-bit busy scoreboard; busy[0] constantly 0.
REQ-011 SHALL set busy[out_rd] on out_valid&&out_ready when out_rd_wen and out_rd!=0.
REQ-012 SHALL clear busy[wb_waddr] when wb_wen and wb_waddr!=0; same-cycle set and clear of one index: set wins.
REQ-013 SHALL, in RESOLVE, declare hazard if rs1 or rs2 (nonzero) is busy and not bypassed (REQ-019); hazard holds RESOLVE.
REQ-014 SHALL, in RESOLVE without hazard, latch operands into out_src1/out_src2 plus rd/rd_wen/pc, and go FULL; out_valid = (state==FULL).
REQ-015 SHALL force operand to 0 when its rs index is 0, regardless of rf data or writeback.
REQ-016 SHALL, in FULL, hold all out_* stable until out_ready; on handshake go RESOLVE if a new instruction is accepted that cycle, else EMPTY.
REQ-017 Latency: accept at edge N, no hazard -> out_valid high from cycle after edge N+1 (2 cycles).

Reset
REQ-018 SHALL on reset assertion, immediately and independent of clock: state EMPTY, busy all 0, out_valid 0, out_src1/out_src2/out_pc 0, out_rd 0, out_rd_wen 0, hold register 0; an in-flight instruction is discarded.

Configuration
REQ-019 With OPFETCH_BYPASS_EN defined: in RESOLVE, if wb_wen and wb_waddr==rsX!=0, operand X SHALL take wb_wdata and count as not busy that cycle (zero-bubble RAW resolution).
REQ-020 Without OPFETCH_BYPASS_EN: no bypass; operand SHALL be read from rf_srcX only, earliest the cycle after busy clears (one extra cycle versus REQ-019).

Verification
REQ-021 No hazard: RF x1=5, x2=7, accept rs1=1 rs2=2 at edge N -> out_valid from cycle after N+1, out_src1=5, out_src2=7, out_pc matches.
REQ-022 RAW: issue rd=3 wen=1, then rs1=3; wb x3=0xAB 4 cycles later -> held in RESOLVE until then; with EN out_src1=0xAB latched on wb cycle; without EN one cycle later.
REQ-023 x0: rs1=0 while wb_wen=1 waddr=0 wdata=0xFF -> out_src1=0, no stall, busy[0] stays 0.
REQ-024 Backpressure: out_ready=0 for 5 cycles in FULL -> out_* stable, in_ready=0; out_ready=1 -> handshake, in_ready=1 same cycle.
REQ-025 Simultaneous: issue rd=5 while wb clears x5 same cycle -> busy[5]=1 afterwards; next rs1=5 stalls.
REQ-026 Reset mid-FULL with busy[7]=1 -> out_valid=0 and busy all 0 before next clock edge; post-reset rs1=7 no stall.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch stage: scoreboarded RAW check between decode and execute.
// Define OPFETCH_BYPASS_EN to forward the writeback port straight into a resolving operand.
module operand_fetch (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic        in_rd_wen,
    input  logic [63:0] in_pc,
    output logic [4:0]  rf_rs1,
    output logic [4:0]  rf_rs2,
    input  logic [63:0] rf_src1,
    input  logic [63:0] rf_src2,
    input  logic [4:0]  wb_waddr,
    input  logic        wb_wen,
    input  logic [63:0] wb_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_src1,
    output logic [63:0] out_src2,
    output logic [4:0]  out_rd,
    output logic        out_rd_wen,
    output logic [63:0] out_pc
);

    typedef enum logic [1:0] {StEmpty, StResolve, StFull} state_e;

    state_e      state_q;
    logic [4:0]  hold_rs1_q;
    logic [4:0]  hold_rs2_q;
    logic [4:0]  hold_rd_q;
    logic        hold_rd_wen_q;
    logic [63:0] hold_pc_q;
    logic [31:0] busy_q;
    logic [31:0] busy_d;

    logic        accept;
    logic        fire;
    logic        byp1;
    logic        byp2;
    logic        hazard;
    logic [63:0] src1;
    logic [63:0] src2;

    assign in_ready  = (state_q == StEmpty) || ((state_q == StFull) && out_ready);
    assign out_valid = (state_q == StFull);
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;
    assign rf_rs1    = hold_rs1_q;
    assign rf_rs2    = hold_rs2_q;

`ifdef OPFETCH_BYPASS_EN
    assign byp1 = wb_wen && (wb_waddr == hold_rs1_q) && (hold_rs1_q != 5'd0);
    assign byp2 = wb_wen && (wb_waddr == hold_rs2_q) && (hold_rs2_q != 5'd0);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    always_comb begin
        hazard = 1'b0;
        if ((hold_rs1_q != 5'd0) && busy_q[hold_rs1_q] && !byp1) hazard = 1'b1;
        if ((hold_rs2_q != 5'd0) && busy_q[hold_rs2_q] && !byp2) hazard = 1'b1;
    end

    // x0 reads as zero no matter what the register file or writeback port carry.
    always_comb begin
        src1 = rf_src1;
        src2 = rf_src2;
        if (byp1) src1 = wb_wdata;
        if (byp2) src2 = wb_wdata;
        if (hold_rs1_q == 5'd0) src1 = 64'd0;
        if (hold_rs2_q == 5'd0) src2 = 64'd0;
    end

    // Clear first so an issue to the same register in the same cycle keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (wb_wen && (wb_waddr != 5'd0)) busy_d[wb_waddr] = 1'b0;
        if (fire && out_rd_wen && (out_rd != 5'd0)) busy_d[out_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StEmpty;
            busy_q        <= 32'd0;
            hold_rs1_q    <= 5'd0;
            hold_rs2_q    <= 5'd0;
            hold_rd_q     <= 5'd0;
            hold_rd_wen_q <= 1'b0;
            hold_pc_q     <= 64'd0;
            out_src1      <= 64'd0;
            out_src2      <= 64'd0;
            out_rd        <= 5'd0;
            out_rd_wen    <= 1'b0;
            out_pc        <= 64'd0;
        end else begin
            busy_q <= busy_d;
            if (accept) begin
                hold_rs1_q    <= in_rs1;
                hold_rs2_q    <= in_rs2;
                hold_rd_q     <= in_rd;
                hold_rd_wen_q <= in_rd_wen;
                hold_pc_q     <= in_pc;
            end
            unique case (state_q)
                StEmpty: begin
                    if (accept) state_q <= StResolve;
                end
                StResolve: begin
                    if (!hazard) begin
                        out_src1   <= src1;
                        out_src2   <= src2;
                        out_rd     <= hold_rd_q;
                        out_rd_wen <= hold_rd_wen_q;
                        out_pc     <= hold_pc_q;
                        state_q    <= StFull;
                    end
                end
                StFull: begin
                    if (out_ready) state_q <= accept ? StResolve : StEmpty;
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: scoreboard on the execute handshake plus timing checks.
// Build with or without OPFETCH_BYPASS_EN to match the RTL build.
module tb_operand_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [4:0]  in_rd = '0;
    logic        in_rd_wen = 1'b0;
    logic [63:0] in_pc = '0;
    logic [4:0]  rf_rs1;
    logic [4:0]  rf_rs2;
    logic [63:0] rf_src1;
    logic [63:0] rf_src2;
    logic [4:0]  wb_waddr = '0;
    logic        wb_wen = 1'b0;
    logic [63:0] wb_wdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_src1;
    logic [63:0] out_src2;
    logic [4:0]  out_rd;
    logic        out_rd_wen;
    logic [63:0] out_pc;

`ifdef OPFETCH_BYPASS_EN
    localparam bit BypassEn = 1'b1;
`else
    localparam bit BypassEn = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] src1;
        logic [63:0] src2;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [63:0] pc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    logic [63:0] rf [32];

    operand_fetch dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .in_rd_wen  (in_rd_wen),
        .in_pc      (in_pc),
        .rf_rs1     (rf_rs1),
        .rf_rs2     (rf_rs2),
        .rf_src1    (rf_src1),
        .rf_src2    (rf_src2),
        .wb_waddr   (wb_waddr),
        .wb_wen     (wb_wen),
        .wb_wdata   (wb_wdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_src1   (out_src1),
        .out_src2   (out_src2),
        .out_rd     (out_rd),
        .out_rd_wen (out_rd_wen),
        .out_pc     (out_pc)
    );

    always #5 clock = ~clock;

    // Raw array: x0 is writable here so the DUT must do its own zeroing.
    always @(posedge clock) if (wb_wen) rf[wb_waddr] <= wb_wdata;
    assign rf_src1 = rf[rf_rs1];
    assign rf_src2 = rf[rf_rs2];

    function automatic logic [63:0] rf_init(input int i);
        if (i == 0) return 64'hDEAD_BEEF_0BAD_F00D;
        if (i == 1) return 64'd5;
        if (i == 2) return 64'd7;
        return 64'h1000 + 64'(i);
    endfunction

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got pc=%h src1=%h with no expected entry",
                         out_pc, out_src1);
            end else begin
                mon_e = sb_q.pop_front();
                if ({out_src1, out_src2, out_rd, out_rd_wen, out_pc} !== mon_e) begin
                    failures++;
                    $display("FAIL sb_data: got src1=%h src2=%h rd=%0d wen=%b pc=%h want src1=%h src2=%h rd=%0d wen=%b pc=%h",
                             out_src1, out_src2, out_rd, out_rd_wen, out_pc,
                             mon_e.src1, mon_e.src2, mon_e.rd, mon_e.rd_wen, mon_e.pc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic wen, input logic [63:0] pc);
        bit done = 1'b0;
        in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_wen = wen; in_pc = pc;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clock);
            if (in_ready) done = 1'b1;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL issue_timeout: pc=%h never accepted, in_ready=%b want 1", pc, in_ready);
        end
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clock);
            if (!out_valid && in_ready && sb_q.size() == 0) done = 1'b1;
        end
        tick();
        if (!done) begin
            checks++; failures++;
            $display("FAIL drain_timeout: out_valid=%b pending=%0d want 0/0", out_valid, sb_q.size());
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready, out_rd, out_rd_wen, rf_rs1, rf_rs2} !== {1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0}
            || out_src1 !== 64'd0 || out_src2 !== 64'd0 || out_pc !== 64'd0) begin
            failures++;
            $display("FAIL reset_state: got valid=%b ready=%b rd=%0d wen=%b src1=%h pc=%h want 0 1 0 0 0 0",
                     out_valid, in_ready, out_rd, out_rd_wen, out_src1, out_pc);
        end
        for (int i = 0; i < 32; i++) begin
            wb_wen = 1'b1; wb_waddr = 5'(i); wb_wdata = rf_init(i);
            tick();
        end
        wb_wen = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_no_hazard();
        sb_q.push_back(exp_t'{64'd5, 64'd7, 5'd4, 1'b0, 64'h1000});
        issue(5'd1, 5'd2, 5'd4, 1'b0, 64'h1000);
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || rf_rs1 !== 5'd1 || rf_rs2 !== 5'd2) begin
            failures++;
            $display("FAIL nohaz_resolve: got valid=%b rf_rs1=%0d rf_rs2=%0d want 0 1 2",
                     out_valid, rf_rs1, rf_rs2);
        end
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL nohaz_latency: got out_valid=%b want 1", out_valid);
        end
        wait_drain();
    endtask

    task automatic test_raw();
        sb_q.push_back(exp_t'{64'd0, 64'd0, 5'd3, 1'b1, 64'h2000});
        issue(5'd0, 5'd0, 5'd3, 1'b1, 64'h2000);
        sb_q.push_back(exp_t'{64'hAB, 64'd7, 5'd0, 1'b0, 64'h2004});
        issue(5'd3, 5'd2, 5'd0, 1'b0, 64'h2004);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL raw_stall: cycle %0d got valid=%b ready=%b want 0 0", i, out_valid, in_ready);
            end
        end
        tick();
        wb_wen = 1'b1; wb_waddr = 5'd3; wb_wdata = 64'hAB;
        tick();
        wb_wen = 1'b0;
        @(negedge clock);
        checks++;
        if (out_valid !== BypassEn) begin
            failures++;
            $display("FAIL raw_release1: got out_valid=%b want %b", out_valid, BypassEn);
        end
        @(negedge clock);
        checks++;
        if (out_valid !== !BypassEn) begin
            failures++;
            $display("FAIL raw_release2: got out_valid=%b want %b", out_valid, !BypassEn);
        end
        wait_drain();
    endtask

    task automatic test_x0();
        wb_wen = 1'b1; wb_waddr = 5'd0; wb_wdata = 64'hFF;
        sb_q.push_back(exp_t'{64'd0, 64'd5, 5'd0, 1'b1, 64'h3000});
        issue(5'd0, 5'd1, 5'd0, 1'b1, 64'h3000);
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL x0_nostall: got out_valid=%b want 1", out_valid);
        end
        wait_drain();
        sb_q.push_back(exp_t'{64'd0, 64'd0, 5'd0, 1'b0, 64'h3008});
        issue(5'd0, 5'd0, 5'd0, 1'b0, 64'h3008);
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL x0_nostall2: got out_valid=%b want 1", out_valid);
        end
        wait_drain();
        wb_wen = 1'b0;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        sb_q.push_back(exp_t'{64'd5, 64'd7, 5'd6, 1'b0, 64'h4000});
        issue(5'd1, 5'd2, 5'd6, 1'b0, 64'h4000);
        @(negedge clock);
        @(negedge clock);
        in_valid = 1'b1; in_rs1 = 5'd2; in_rs2 = 5'd1; in_rd = 5'd0; in_rd_wen = 1'b0; in_pc = 64'h4004;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_src1 !== 64'd5 || out_src2 !== 64'd7
                || out_rd !== 5'd6 || out_pc !== 64'h4000) begin
                failures++;
                $display("FAIL bp_hold: cycle %0d got valid=%b ready=%b src1=%h src2=%h rd=%0d pc=%h want 1 0 5 7 6 4000",
                         i, out_valid, in_ready, out_src1, out_src2, out_rd, out_pc);
            end
            @(negedge clock);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        sb_q.push_back(exp_t'{64'd7, 64'd5, 5'd0, 1'b0, 64'h4004});
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: got ready=%b valid=%b want 1 1", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_simultaneous();
        sb_q.push_back(exp_t'{64'd0, 64'd0, 5'd5, 1'b1, 64'h5000});
        issue(5'd0, 5'd0, 5'd5, 1'b1, 64'h5000);
        tick();
        wb_wen = 1'b1; wb_waddr = 5'd5; wb_wdata = 64'h55;
        in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd0; in_rd = 5'd0; in_rd_wen = 1'b0; in_pc = 64'h5004;
        sb_q.push_back(exp_t'{64'h77, 64'd0, 5'd0, 1'b0, 64'h5004});
        tick();
        wb_wen = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL sim_stall: cycle %0d got out_valid=%b want 0", i, out_valid);
            end
        end
        tick();
        wb_wen = 1'b1; wb_waddr = 5'd5; wb_wdata = 64'h77;
        tick();
        wb_wen = 1'b0;
        wait_drain();
    endtask

    task automatic test_reset_mid_full();
        sb_q.push_back(exp_t'{64'd0, 64'd0, 5'd7, 1'b1, 64'h6000});
        issue(5'd0, 5'd0, 5'd7, 1'b1, 64'h6000);
        issue(5'd1, 5'd0, 5'd0, 1'b0, 64'h6004);
        out_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rmf_full: got out_valid=%b want 1", out_valid);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready, out_rd, out_rd_wen, rf_rs1} !== {1'b0, 1'b1, 5'd0, 1'b0, 5'd0}
            || out_src1 !== 64'd0 || out_pc !== 64'd0) begin
            failures++;
            $display("FAIL rmf_reset: got valid=%b ready=%b rd=%0d wen=%b rs1=%0d src1=%h pc=%h want 0 1 0 0 0 0 0",
                     out_valid, in_ready, out_rd, out_rd_wen, rf_rs1, out_src1, out_pc);
        end
        sb_q.delete();
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        sb_q.push_back(exp_t'{rf_init(7), 64'd0, 5'd0, 1'b0, 64'h6008});
        issue(5'd7, 5'd0, 5'd0, 1'b0, 64'h6008);
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rmf_nostall: got out_valid=%b want 1", out_valid);
        end
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_no_hazard();
        test_raw();
        test_x0();
        test_backpressure();
        test_simultaneous();
        test_reset_mid_full();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: got %0d pending want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
